ultrasound_scheduler: RTL and testbench

Round-robin sequencer for the car's six ultrasonic rangefinders (trigger/echo pairs U0–U5). It fires one sensor at a time to avoid acoustic crosstalk, measures each echo pulse width in clock cycles, and holds the latest result per channel for the NIOS bus slave that wraps it. It sits between the Avalon register file and the sensor trigger and feedback pins.

---
 rtl/ultrasound_scheduler.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ultrasound_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasound_scheduler.sv
// Round-robin trigger/echo sequencer for up to eight ultrasonic rangefinders.
// Define US_SCHED_FILTER_EN to add a 3-sample stability filter on each synchronized echo.
module ultrasound_scheduler #(
    parameter int NUM_CH         = 6,
    parameter int CNT_W          = 21,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] feedback_in,
    output logic [NUM_CH-1:0] trigger_out,
    input  logic [2:0]        rd_addr,
    input  logic              rd_strobe,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] fresh,
    output logic [NUM_CH-1:0] timeout,
    output logic              busy,
    output logic [2:0]        cur_ch,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GUARD} state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          cur_ch_q, cur_ch_d;
    logic                wr_pend_q, wr_pend_d;
    logic                wr_to_q, wr_to_d;
    logic [CNT_W-1:0]    wr_val_q, wr_val_d;
    logic [NUM_CH-1:0]   trigger_q, trigger_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   fresh_q, fresh_d;
    logic [NUM_CH-1:0]   timeout_q, timeout_d;
    logic [CNT_W-1:0]    result_q [NUM_CH];
    logic [CNT_W-1:0]    result_d [NUM_CH];
    logic [NUM_CH-1:0]   sync1_q, sync1_d;
    logic [NUM_CH-1:0]   sync2_q, sync2_d;
    logic [NUM_CH-1:0]   echo_s;

    // Lowest set mask bit strictly above cur, wrapping through bit 0 back to cur itself.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [NUM_CH-1:0] mask);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(cur) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!found && mask[idx]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

`ifdef US_SCHED_FILTER_EN
    logic [NUM_CH-1:0] hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;

    // Filter output follows a channel only once three consecutive samples agree.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = filt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((sync2_q[i] == hist1_q[i]) && (hist1_q[i] == hist2_q[i])) begin
                filt_d[i] = sync2_q[i];
            end else begin
                filt_d[i] = filt_q[i];
            end
        end
    end

    // Filter history and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist1_q <= '0;
            hist2_q <= '0;
            filt_q  <= '0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign echo_s = filt_q;
`else
    assign echo_s = sync2_q;
`endif

    // Sequencer: next state, shared cycle counter and pending result write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_ch_d  = cur_ch_q;
        wr_pend_d = 1'b0;
        wr_to_d   = 1'b0;
        wr_val_d  = wr_val_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    state_d  = S_TRIG;
                    cur_ch_d = next_ch(cur_ch_q, ch_mask);
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            S_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_RISE: begin
                if (echo_s[cur_ch_q]) begin
                    // The cycle that sees the rising edge already counts toward the width.
                    state_d = S_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d   = S_GUARD;
                    cnt_d     = CNT_ZERO;
                    wr_pend_d = 1'b1;
                    wr_to_d   = 1'b1;
                    wr_val_d  = TIMEOUT_V;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_MEASURE: begin
                if (cnt_q == TIMEOUT_V) begin
                    state_d   = S_GUARD;
                    cnt_d     = CNT_ZERO;
                    wr_pend_d = 1'b1;
                    wr_to_d   = 1'b1;
                    wr_val_d  = TIMEOUT_V;
                end else if (echo_s[cur_ch_q]) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d   = S_GUARD;
                    cnt_d     = CNT_ZERO;
                    wr_pend_d = 1'b1;
                    wr_val_d  = cnt_q;
                end
            end
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (enable && (ch_mask != '0)) begin
                        state_d  = S_TRIG;
                        cur_ch_d = next_ch(cur_ch_q, ch_mask);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output registers, result bank and per-channel status; a write beats a coincident read clear.
    always_comb begin
        sync1_d   = feedback_in;
        sync2_d   = sync1_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = wr_pend_q;
        fresh_d   = fresh_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        trigger_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trigger_d[i] = (state_q == S_TRIG) && (cur_ch_q == 3'(i));
            if (wr_pend_q && (cur_ch_q == 3'(i))) begin
                result_d[i]  = wr_val_q;
                fresh_d[i]   = 1'b1;
                timeout_d[i] = wr_to_q;
            end else if (rd_strobe && (rd_addr == 3'(i))) begin
                fresh_d[i] = 1'b0;
            end else begin
                fresh_d[i] = fresh_q[i];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            cur_ch_q  <= LAST_CH;
            wr_pend_q <= 1'b0;
            wr_to_q   <= 1'b0;
            wr_val_q  <= CNT_ZERO;
            trigger_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fresh_q   <= '0;
            timeout_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= CNT_ZERO;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_ch_q  <= cur_ch_d;
            wr_pend_q <= wr_pend_d;
            wr_to_q   <= wr_to_d;
            wr_val_q  <= wr_val_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fresh_q   <= fresh_d;
            timeout_q <= timeout_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            result_q  <= result_d;
        end
    end

    // Read mux; addresses beyond the channel count read as zero.
    always_comb begin
        if (32'(rd_addr) < NUM_CH) begin
            rd_data = result_q[rd_addr];
        end else begin
            rd_data = CNT_ZERO;
        end
    end

    assign trigger_out = trigger_q;
    assign fresh       = fresh_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
    assign cur_ch      = cur_ch_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ultrasound_scheduler.sv
// Directed self-checking bench for ultrasound_scheduler with shortened trigger/timeout/guard times.
module tb_ultrasound_scheduler;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 21;
    localparam int TO     = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] feedback_in;
    logic [NUM_CH-1:0] trigger_out;
    logic [2:0]        rd_addr;
    logic              rd_strobe;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] fresh;
    logic [NUM_CH-1:0] timeout;
    logic              busy;
    logic [2:0]        cur_ch;
    logic              done;

    int chk_cnt = 0;
    int err_cnt = 0;

    ultrasound_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TRIG_CYCLES(4),
        .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .feedback_in(feedback_in), .trigger_out(trigger_out), .rd_addr(rd_addr),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .fresh(fresh), .timeout(timeout),
        .busy(busy), .cur_ch(cur_ch), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input int budget, output int cycles);
        cycles = 0;
        while (trigger_out == 6'd0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_val("trig_seen", 32'(trigger_out != 6'd0), 32'd1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    task automatic pulse(input int ch, input int len);
        feedback_in[ch] = 1'b1;
        repeat (len) @(negedge clk);
        feedback_in[ch] = 1'b0;
    endtask

    initial begin
        int n;
        int len;
        reset       = 1'b1;
        enable      = 1'b0;
        ch_mask     = 6'd0;
        feedback_in = 6'd0;
        rd_addr     = 3'd0;
        rd_strobe   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_trig", 32'(trigger_out), 32'd0);
        check_val("rst_fresh", 32'(fresh), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_cur_ch", 32'(cur_ch), 32'd5);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);

        // Channel 0: 37-cycle echo
        reset   = 1'b0;
        ch_mask = 6'b000101;
        enable  = 1'b1;
        wait_trig(20, n);
        check_val("trig_ch0", 32'(trigger_out), 32'd1);
        len = 0;
        while (trigger_out != 6'd0 && len < 50) begin
            @(negedge clk);
            len++;
        end
        check_val("trig_len", 32'(len), 32'd4);
        repeat (3) @(negedge clk);
        pulse(0, 37);
        wait_done(40, n);
        check_val("res0_37pm1", 32'(rd_data >= 21'd36 && rd_data <= 21'd38), 32'd1);
        check_val("fresh0", 32'(fresh[0]), 32'd1);
        check_val("timeout0_clr", 32'(timeout[0]), 32'd0);
        @(negedge clk);
        check_val("done_one_cycle", 32'(done), 32'd0);
        wait_trig(30, n);
        check_val("guard_gap", 32'(n + 1), 32'd10);
        check_val("trig_ch2", 32'(trigger_out), 32'd4);

        // Channel 2: no echo -> timeout
        rd_addr = 3'd2;
        wait_done(200, n);
        #1;
        check_val("res2_to", 32'(rd_data), 32'(TO));
        check_val("timeout2", 32'(timeout[2]), 32'd1);
        check_val("fresh2", 32'(fresh[2]), 32'd1);
        wait_trig(30, n);
        check_val("wrap_ch0", 32'(trigger_out), 32'd1);

        // Plain read clears fresh[0]
        rd_addr   = 3'd0;
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        check_val("rd_clear0", 32'(fresh[0]), 32'd0);

        // Saturating echo with a read strobe held across the result write
        rd_strobe = 1'b1;
        repeat (6) @(negedge clk);
        feedback_in[0] = 1'b1;
        wait_done(150, n);
        rd_strobe = 1'b0;
        check_val("fresh_wr_wins", 32'(fresh[0]), 32'd1);
        check_val("sat_res", 32'(rd_data), 32'(TO));
        check_val("sat_timeout", 32'(timeout[0]), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check_val("fresh_hold", 32'(fresh[0]), 32'd1);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        check_val("fresh_clr_later", 32'(fresh[0]), 32'd0);
        repeat (190) @(negedge clk);
        feedback_in[0] = 1'b0;
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_trig", 32'(trigger_out), 32'd0);
        check_val("sat_no_wrap", 32'(rd_data), 32'(TO));
        enable = 1'b1;
        wait_trig(20, n);
        check_val("resume_ch2", 32'(trigger_out), 32'd4);
        wait_done(200, n);
        wait_trig(30, n);
        check_val("trig_ch0_b", 32'(trigger_out), 32'd1);

        // Normal result after timeout clears timeout[0]
        repeat (6) @(negedge clk);
        pulse(0, 20);
        wait_done(40, n);
        check_val("res0_20", 32'(rd_data), 32'd20);
        check_val("timeout0_cleared", 32'(timeout[0]), 32'd0);

        // Reset in the middle of a measurement on channel 2
        wait_trig(30, n);
        check_val("trig_ch2_b", 32'(trigger_out), 32'd4);
        repeat (6) @(negedge clk);
        feedback_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_trig", 32'(trigger_out), 32'd0);
        check_val("mid_rst_fresh", 32'(fresh), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        feedback_in = 6'd0;
        ch_mask     = 6'b000110;
        rd_addr     = 3'd2;
        @(negedge clk);
        check_val("no_partial", 32'(rd_data), 32'd0);
        reset = 1'b0;
        wait_trig(20, n);
        check_val("first_after_rst", 32'(trigger_out), 32'd2);

        // Two-cycle echo glitch on channel 1
        rd_addr = 3'd1;
        repeat (8) @(negedge clk);
        pulse(1, 2);
        wait_done(200, n);
`ifdef US_SCHED_FILTER_EN
        check_val("glitch_res", 32'(rd_data), 32'(TO));
        check_val("glitch_to", 32'(timeout[1]), 32'd1);
`else
        check_val("glitch_res", 32'(rd_data), 32'd2);
        check_val("glitch_to", 32'(timeout[1]), 32'd0);
`endif

        // Single-bit mask keeps reselecting the same channel
        wait_trig(30, n);
        check_val("trig_ch2_c", 32'(trigger_out), 32'd4);
        ch_mask = 6'b000100;
        wait_done(200, n);
        wait_trig(30, n);
        check_val("single_mask", 32'(trigger_out), 32'd4);
        rd_addr = 3'd7;
        #1;
        check_val("rd_oob", 32'(rd_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
